multicycle_controller: RTL

- Multi-cycle sequencer for the RISC-V core's datapath: fetch, decode, execute, memory and writeback.
- Each instruction spans several cycles.
- Drives the latched opcode into the immediate unit and the ALU operand-B select.
- Handshakes with a shared instruction/data memory and counts retired instructions.

---
 rtl/multicycle_controller.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RISC-V core datapath.
// Drives memory handshake, datapath selects and a retired-instruction counter.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instruction_i,
    input  logic                mem_ready_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic                addr_sel_o,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic [1:0]          alu_src_b_o,
    output logic [6:0]          imm_op_o,
    output logic                reg_write_o,
    output logic                mem_to_reg_o,
    output logic                illegal_o,
    output logic                retire_o,
    output logic [RETIRE_W-1:0] retired_count_o,
    output logic [2:0]          state_o
);

    // state   | meaning
    // FETCH   | request instruction at PC, load IR and PC+4 on ready
    // DECODE  | latch opcode, reject unsupported opcodes
    // EXECUTE | ALU operation, select operand B
    // MEM     | data access at ALU address (LOAD/STORE)
    // WB      | register-file write and retire
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t                state_q, state_d;
    logic [6:0]            opcode_q;
    logic [RETIRE_W-1:0]   count_q;

    logic       mem_req, mem_we, addr_sel, ir_write, pc_write;
    logic [1:0] alu_b;
    logic       reg_write, mem_to_reg, illegal, retire;
    logic       unused_ir_bits;

    assign unused_ir_bits = ^instruction_i[31:7];

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LUI) ||
               (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                opcode_q <= instruction_i[6:0];
            if (retire)
                count_q <= count_q + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        alu_b      = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alu_b   = 2'b01;
                if (mem_ready_i) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            // Decision uses the live IR; the latched copy is valid from EXECUTE on.
            S_DECODE: begin
                if (op_legal(instruction_i[6:0])) begin
                    state_d = S_EXECUTE;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_b   = (opcode_q == OP_R) ? 2'b00 : 2'b10;
                state_d = (opcode_q == OP_LOAD || opcode_q == OP_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode_q == OP_STORE);
                if (mem_ready_i) begin
                    if (opcode_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode_q == OP_LOAD);
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Everything is held at zero while reset is low, including the memory request.
    assign mem_req_o       = reset & mem_req;
    assign mem_we_o        = reset & mem_we;
    assign addr_sel_o      = reset & addr_sel;
    assign ir_write_o      = reset & ir_write;
    assign pc_write_o      = reset & pc_write;
    assign alu_src_b_o     = reset ? alu_b : 2'b00;
    assign imm_op_o        = reset ? opcode_q : 7'd0;
    assign reg_write_o     = reset & reg_write;
    assign mem_to_reg_o    = reset & mem_to_reg;
    assign illegal_o       = reset & illegal;
    assign retire_o        = reset & retire;
    assign retired_count_o = reset ? count_q : '0;
    assign state_o         = reset ? state_q : 3'd0;

endmodule
